// File: rtl/axi4_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite master.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back. All AXI VALID/READY outputs are decodes of registered state.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic [ADDRESS-1:0]        M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,

    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,

    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,

    output logic [ADDRESS-1:0]        M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,

    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                 state_q,  state_d;
    logic [ADDRESS-1:0]     addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,  wdata_d;
    logic [STRB_W-1:0]      wstrb_q,  wstrb_d;
    logic [DATA_WIDTH-1:0]  rdata_q,  rdata_d;
    logic [1:0]             resp_q,   resp_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q,  w_done_d;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WRITE : RADDR;
                end
            end
            WRITE: begin
                // Each channel retires independently; both may finish in one cycle.
                if (M_AWVALID && M_AWREADY) aw_done_d = 1'b1;
                if (M_WVALID && M_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = WRESP;
            end
            WRESP: begin
                if (M_BVALID) begin
                    resp_d  = M_BRESP;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RADDR: begin
                if (M_ARREADY) state_d = RDATA;
            end
            RDATA: begin
                if (M_RVALID) begin
                    rdata_d = M_RDATA;
                    resp_d  = M_RRESP;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with ARESET keeps cmd_ready low for the whole reset pulse.
    assign cmd_ready = (state_q == IDLE) && !ARESET;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign M_AWADDR  = addr_q;
    assign M_AWVALID = (state_q == WRITE) && !aw_done_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = (state_q == WRITE) && !w_done_q;
    assign M_BREADY  = (state_q == WRESP);
    assign M_ARADDR  = addr_q;
    assign M_ARVALID = (state_q == RADDR);
    assign M_RREADY  = (state_q == RDATA);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: reactive slave model plus response scoreboard.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [3:0]  M_WSTRB;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] exp_q[$];
    logic [31:0] exp_mem [16];
    logic [31:0] slv_mem [16];
    int cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0, cfg_ar_delay = 0, cfg_r_delay = 0;
    int cfg_hold = 0;
    logic [1:0] cfg_bresp = RESP_OKAY;
    logic [1:0] cfg_rresp = RESP_OKAY;
    int n_wr = 0;
    int b_hs_count = 0;
    int n_rsp = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Drive one command; returns one cycle after acceptance with the wait count.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit keep, output int waits);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        cmd_valid = 1'b1;
        waits = 0;
        while (!cmd_ready && waits < 50) begin
            @(negedge ACLK);
            waits++;
        end
        if (!cmd_ready) begin
            check_eq("accept_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (wr) begin
            exp_mem[addr[5:2]] = merge(exp_mem[addr[5:2]], data, strb);
            exp_q.push_back({cfg_bresp, 32'h0});
            n_wr++;
        end else begin
            exp_q.push_back({cfg_rresp, exp_mem[addr[5:2]]});
        end
        @(negedge ACLK);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(cmd_ready && exp_q.size() == 0) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 200) check_eq("idle_timeout", 64'(cmd_ready && exp_q.size() == 0), 64'd1);
    endtask

    // Slave model and handshake monitor, acting just after each falling edge.
    initial begin
        logic aw_got, w_got, ar_got, rst_prev;
        logic prev_awvalid, prev_wvalid, prev_arvalid, prev_bready;
        logic [31:0] aw_addr, w_data, ar_addr, prev_awaddr, prev_wdata, prev_araddr;
        logic [3:0] w_strb;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID} = '0;
        M_BRESP = 2'b00; M_RRESP = 2'b00; M_RDATA = '0;
        {aw_got, w_got, ar_got, rst_prev} = '1;
        {prev_awvalid, prev_wvalid, prev_arvalid, prev_bready} = '0;
        {aw_addr, w_data, ar_addr, prev_awaddr, prev_wdata, prev_araddr} = '0;
        w_strb = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        forever begin
            @(negedge ACLK);
            #1;
            if (!rst_prev) begin
                if (prev_awvalid && M_AWREADY) check_eq("aw_drop", 64'(M_AWVALID), 64'd0);
                else if (prev_awvalid) begin
                    check_eq("aw_hold", 64'(M_AWVALID), 64'd1);
                    check_eq("aw_addr_stable", 64'(M_AWADDR), 64'(prev_awaddr));
                end
                if (prev_wvalid && M_WREADY) check_eq("w_drop", 64'(M_WVALID), 64'd0);
                else if (prev_wvalid) begin
                    check_eq("w_hold", 64'(M_WVALID), 64'd1);
                    check_eq("w_data_stable", 64'(M_WDATA), 64'(prev_wdata));
                end
                if (prev_arvalid && M_ARREADY) check_eq("ar_drop", 64'(M_ARVALID), 64'd0);
                else if (prev_arvalid) begin
                    check_eq("ar_hold", 64'(M_ARVALID), 64'd1);
                    check_eq("ar_addr_stable", 64'(M_ARADDR), 64'(prev_araddr));
                end
                if (prev_bready && M_BVALID) b_hs_count++;
            end
            if (ARESET) begin
                {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID} = '0;
                {aw_got, w_got, ar_got} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
            end else begin
                M_AWREADY = 1'b0;
                if (M_AWVALID && !aw_got) begin
                    if (aw_cnt >= cfg_aw_delay) begin
                        M_AWREADY = 1'b1; aw_got = 1'b1; aw_addr = M_AWADDR; aw_cnt = 0;
                    end else aw_cnt++;
                end
                M_WREADY = 1'b0;
                if (M_WVALID && !w_got) begin
                    if (w_cnt >= cfg_w_delay) begin
                        M_WREADY = 1'b1; w_got = 1'b1; w_data = M_WDATA; w_strb = M_WSTRB; w_cnt = 0;
                    end else w_cnt++;
                end
                M_BVALID = 1'b0;
                if (M_BREADY && aw_got && w_got) begin
                    if (b_cnt >= cfg_b_delay) begin
                        M_BVALID = 1'b1; M_BRESP = cfg_bresp;
                        slv_mem[aw_addr[5:2]] = merge(slv_mem[aw_addr[5:2]], w_data, w_strb);
                        aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
                    end else b_cnt++;
                end
                M_ARREADY = 1'b0;
                if (M_ARVALID && !ar_got) begin
                    if (ar_cnt >= cfg_ar_delay) begin
                        M_ARREADY = 1'b1; ar_got = 1'b1; ar_addr = M_ARADDR; ar_cnt = 0;
                    end else ar_cnt++;
                end
                M_RVALID = 1'b0;
                if (M_RREADY && ar_got) begin
                    if (r_cnt >= cfg_r_delay) begin
                        M_RVALID = 1'b1; M_RDATA = slv_mem[ar_addr[5:2]]; M_RRESP = cfg_rresp;
                        ar_got = 1'b0; r_cnt = 0;
                    end else r_cnt++;
                end
            end
            prev_awvalid = M_AWVALID; prev_awaddr = M_AWADDR;
            prev_wvalid  = M_WVALID;  prev_wdata  = M_WDATA;
            prev_arvalid = M_ARVALID; prev_araddr = M_ARADDR;
            prev_bready  = M_BREADY;
            rst_prev     = ARESET;
        end
    end

    // Response consumer: optional backpressure, then pop and compare.
    initial begin
        logic in_rsp;
        int hold_left;
        logic [31:0] snap_data;
        logic [1:0] snap_resp;
        logic [33:0] e;
        rsp_ready = 1'b1;
        in_rsp = 1'b0;
        hold_left = 0;
        snap_data = '0;
        snap_resp = '0;
        forever begin
            @(negedge ACLK);
            #1;
            if (ARESET) begin
                in_rsp = 1'b0;
                rsp_ready = 1'b1;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1; hold_left = cfg_hold;
                    snap_data = rsp_rdata; snap_resp = rsp_resp;
                end else begin
                    check_eq("rsp_data_stable", 64'(rsp_rdata), 64'(snap_data));
                    check_eq("rsp_resp_stable", 64'(rsp_resp), 64'(snap_resp));
                end
                if (hold_left > 0) begin
                    rsp_ready = 1'b0;
                    check_eq("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                    hold_left--;
                end else begin
                    rsp_ready = 1'b1;
                    in_rsp = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        n_rsp++;
                        $display("rsp %0d: rdata=0x%08h resp=%0d (exp 0x%08h/%0d)",
                                 n_rsp, rsp_rdata, rsp_resp, e[31:0], e[33:32]);
                        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
                        check_eq("rsp_resp", 64'(rsp_resp), 64'(e[33:32]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, n;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 32'hA000_0000 | 32'(i);
            slv_mem[i] = 32'hA000_0000 | 32'(i);
        end
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        repeat (3) @(negedge ACLK);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, rsp_valid}), 64'd0);
        check_eq("rst_outputs", 64'({M_AWADDR, rsp_rdata}), 64'd0);
        check_eq("rst_resp", 64'(rsp_resp), 64'd0);
        ARESET = 1'b0;
        #1;
        check_eq("rst_release_ready", 64'(cmd_ready), 64'd1);

        // Zero-wait write, cycle-exact
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1'b0, w);
        check_eq("wr_c1_awvalid", 64'(M_AWVALID), 64'd1);
        check_eq("wr_c1_wvalid", 64'(M_WVALID), 64'd1);
        check_eq("wr_c1_bready", 64'(M_BREADY), 64'd0);
        @(negedge ACLK);
        check_eq("wr_c2_bready", 64'(M_BREADY), 64'd1);
        check_eq("wr_c2_valids", 64'({M_AWVALID, M_WVALID}), 64'd0);
        @(negedge ACLK);
        check_eq("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        wait_idle();

        // Zero-wait read of the same address, cycle-exact
        issue(1'b0, 32'h4, 32'h0, 4'h0, 1'b0, w);
        check_eq("rd_c1_arvalid", 64'(M_ARVALID), 64'd1);
        @(negedge ACLK);
        check_eq("rd_c2_rready", 64'(M_RREADY), 64'd1);
        check_eq("rd_c2_arvalid", 64'(M_ARVALID), 64'd0);
        @(negedge ACLK);
        check_eq("rd_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("rd_c3_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        wait_idle();

        // AW accepted three cycles before W
        cfg_w_delay = 3;
        issue(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, w);
        @(negedge ACLK);
        check_eq("split_aw_dropped", 64'(M_AWVALID), 64'd0);
        check_eq("split_w_held", 64'(M_WVALID), 64'd1);
        check_eq("split_no_bready", 64'(M_BREADY), 64'd0);
        wait_idle();
        cfg_w_delay = 0;

        // Slow read with SLVERR
        cfg_ar_delay = 2; cfg_r_delay = 5; cfg_rresp = RESP_SLVERR;
        issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, w);
        wait_idle();
        cfg_ar_delay = 0; cfg_r_delay = 0; cfg_rresp = RESP_OKAY;

        // Partial-strobe write with DECERR, then read back
        cfg_bresp = RESP_DECERR;
        issue(1'b1, 32'h8, 32'h11223344, 4'h3, 1'b0, w);
        wait_idle();
        cfg_bresp = RESP_OKAY;
        issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, w);
        wait_idle();

        // Response backpressure with a command presented during RESP
        cfg_hold = 4;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, w);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
        check_eq("hold_rsp_seen", 64'(rsp_valid), 64'd1);
        cmd_write = 1'b1; cmd_addr = 32'h3C; cmd_wdata = 32'h0BAD0BAD; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        repeat (3) begin
            check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            @(negedge ACLK);
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge ACLK);
        check_eq("hold_cmd_ignored", 64'({M_AWVALID, M_ARVALID}), 64'd0);
        cfg_hold = 0;

        // Reset in the middle of a write
        cfg_aw_delay = 10; cfg_w_delay = 10;
        issue(1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, w);
        check_eq("mid_rst_awvalid", 64'(M_AWVALID), 64'd1);
        ARESET = 1'b1;
        void'(exp_q.pop_back());
        n_wr--;
        @(negedge ACLK);
        check_eq("mid_rst_valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        ARESET = 1'b0;
        cfg_aw_delay = 0; cfg_w_delay = 0;
        #1;
        check_eq("mid_rst_release_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge ACLK);
        check_eq("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);

        // Back-to-back write then read with cmd_valid held
        issue(1'b1, 32'h14, 32'h5A5A5A5A, 4'hF, 1'b1, w);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, w2);
        check_eq("b2b_accept_wait", 64'(w2), 64'd3);
        wait_idle();

        // Short random mix
        for (int i = 0; i < 10; i++) begin
            cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3);
            cfg_b_delay = $urandom_range(0, 2); cfg_ar_delay = $urandom_range(0, 3);
            cfg_r_delay = $urandom_range(0, 3); cfg_hold = $urandom_range(0, 2);
            cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom,
                  4'($urandom_range(0, 15)), 1'b0, w);
            wait_idle();
        end

        repeat (3) @(negedge ACLK);
        check_eq("b_handshakes", 64'(b_hs_count), 64'(n_wr));
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite master that turns a simple command/response interface into AXI4-Lite read and write transactions. It sits between an internal controller (CPU-side bus, test sequencer, DMA descriptor engine) and any AXI4-Lite slave in the design. It drives all five channels and holds each VALID until its handshake completes. It returns the slave's read data and response code to the requester.

## Interface
- ADDRESS, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; WSTRB is DATA_WIDTH/8 bits
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS  transaction address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester takes response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  RRESP or BRESP from slave
- M_AWADDR/M_AWVALID out ADDRESS/1, M_AWREADY in 1: write address channel
- M_WDATA/M_WSTRB/M_WVALID out DATA_WIDTH/DATA_WIDTH/8/1, M_WREADY in 1: write data channel
- M_BRESP in 2, M_BVALID in 1, M_BREADY out 1: write response channel
- M_ARADDR/M_ARVALID out ADDRESS/1, M_ARREADY in 1: read address channel
- M_RDATA in DATA_WIDTH, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1: read data channel

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE: cmd_ready = 1. On accept, latch addr/wdata/wstrb. Go to WRITE if cmd_write, otherwise RADDR.
- WRITE: AWVALID and WVALID assert together. Each channel has a done flag (aw_done, w_done). A channel's VALID drops the cycle after its own handshake, independent of the other channel. Go to WRESP when both flags are set, including the case where both handshake in the same cycle.
- WRESP: BREADY = 1. On BVALID && BREADY, latch BRESP, set rsp_rdata = 0, go to RESP.
- RADDR: ARVALID = 1. On ARVALID && ARREADY, go to RDATA.
- RDATA: RREADY = 1. On RVALID && RREADY, latch RDATA/RRESP, go to RESP.
- RESP: rsp_valid = 1, held stable until rsp_ready; then go to IDLE.
- Address, data and strobe outputs come from registers and are stable while the corresponding VALID is high.
- SLVERR/DECERR are passed through unchanged. No retry.
- No timeout: a slave that never responds stalls the block until reset.

## Timing
- Reset: all VALID/READY outputs 0, cmd_ready 0, rsp_valid 0, all address/data/resp outputs 0. State returns to IDLE. cmd_ready reads 1 in the first cycle after ARESET deasserts.
- Reset mid-transaction: every VALID drops at the next edge. The transaction is abandoned and no response is produced.
- Write with zero-wait slave: accept at cycle 0. AW/W VALID in cycle 1. BREADY in cycle 2; BVALID sampled from cycle 2. rsp_valid in cycle 3. Minimum 4 cycles command-to-IDLE, given rsp_ready = 1.
- Read with zero-wait slave: ARVALID in cycle 1, RREADY in cycle 2, rsp_valid in cycle 3.
- VALID never depends combinationally on READY. READY outputs are pure state decodes.
- cmd_valid is ignored outside IDLE. Exactly one transaction is outstanding.

## Structure
- Shared package axi4_lite_pkg:
  - state enum typedef
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
- Single module, no sub-modules. The AW/W done-flag tracking is inline logic.

## Test plan
- Write addr 0x4, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AW/W handshake in the same cycle, rsp_valid cycle 3 with rsp_resp 00. Read of 0x4 then returns 0xDEADBEEF.
- Write where AWREADY arrives 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID stays high until WREADY, single BREADY phase, one response.
- Read addr 0x8 where the slave returns RRESP = 2'b10 after 5 wait cycles -> ARVALID held 1 until ARREADY, rsp_resp = 2'b10, rsp_rdata = slave data.
- rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stable, cmd_ready 0, a new cmd_valid is ignored.
- ARESET asserted while in WRITE with AWVALID high -> next cycle all VALIDs are 0, no rsp_valid, cmd_ready 1 after reset release.
- Back-to-back write then read with cmd_valid held high -> second command accepted the cycle after the first response completes, never earlier.
